// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - dual-issue writeback stage with skid buffer, write-conflict resolution and forwarding
// Optional trace outputs and commit counter: define WB_COMMIT_TRACE_EN
module wb_commit_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              commit_stall,
    input  logic [1:0]        mem_valid,
    output logic              wb_ready,
    input  logic [DATA_W-1:0] mem_pc1,
    input  logic [DATA_W-1:0] mem_pc2,
    input  logic [1:0]        mem_reg_we,
    input  logic [ADDR_W-1:0] mem_reg_waddr1,
    input  logic [ADDR_W-1:0] mem_reg_waddr2,
    input  logic [DATA_W-1:0] mem_reg_wdata1,
    input  logic [DATA_W-1:0] mem_reg_wdata2,
    output logic [1:0]        reg_write_en,
    output logic [ADDR_W-1:0] reg_write_addr1,
    output logic [ADDR_W-1:0] reg_write_addr2,
    output logic [DATA_W-1:0] reg_write_data1,
    output logic [DATA_W-1:0] reg_write_data2,
    output logic [1:0]        fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr1,
    output logic [ADDR_W-1:0] fwd_addr2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
`ifdef WB_COMMIT_TRACE_EN
    ,
    output logic [DATA_W-1:0] debug_wb_pc1,
    output logic [DATA_W-1:0] debug_wb_pc2,
    output logic [1:0]        debug_wb_rf_we,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum1,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum2,
    output logic [DATA_W-1:0] debug_wb_rf_wdata1,
    output logic [DATA_W-1:0] debug_wb_rf_wdata2,
    output logic [31:0]       commit_cnt
`endif
);

    typedef struct packed {
        logic [1:0]        valid;
        logic [DATA_W-1:0] pc1;
        logic [DATA_W-1:0] pc2;
        logic [1:0]        we;
        logic [ADDR_W-1:0] waddr1;
        logic [ADDR_W-1:0] waddr2;
        logic [DATA_W-1:0] wdata1;
        logic [DATA_W-1:0] wdata2;
    } pair_t;

    pair_t s_q, s_d;
    pair_t k_q, k_d;
    pair_t in_pair;

    logic accept;
    logic retire;
    logic en0;
    logic en1;
    logic conflict;

    // Ready depends only on the skid register so MEM never sees a stall-to-ready path.
    assign wb_ready = ~(|k_q.valid);
    assign accept   = (|mem_valid) & wb_ready & ~flush;
    assign retire   = (|s_q.valid) & ~commit_stall & ~flush;

    // Bundle the offered MEM pair into the stage payload format.
    always_comb begin
        in_pair        = '0;
        in_pair.valid  = mem_valid;
        in_pair.pc1    = mem_pc1;
        in_pair.pc2    = mem_pc2;
        in_pair.we     = mem_reg_we;
        in_pair.waddr1 = mem_reg_waddr1;
        in_pair.waddr2 = mem_reg_waddr2;
        in_pair.wdata1 = mem_reg_wdata1;
        in_pair.wdata2 = mem_reg_wdata2;
    end

    // Routing: skid drains into the stage first so MEM pairs never overtake older ones.
    always_comb begin
        s_d = s_q;
        k_d = k_q;
        if (flush) begin
            s_d = '0;
            k_d = '0;
        end else if (|k_q.valid) begin
            if (retire) begin
                s_d = k_q;
                k_d = '0;
            end
        end else if (!(|s_q.valid) || retire) begin
            s_d = accept ? in_pair : '0;
        end else if (accept) begin
            k_d = in_pair;
        end
    end

    // Stage and skid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
            k_q <= '0;
        end else begin
            s_q <= s_d;
            k_q <= k_d;
        end
    end

    // Per-slot enables; on same destination the younger slot1 write wins.
    always_comb begin
        en0          = s_q.valid[0] & s_q.we[0] & (s_q.waddr1 != '0) & ~commit_stall & ~flush;
        en1          = s_q.valid[1] & s_q.we[1] & (s_q.waddr2 != '0) & ~commit_stall & ~flush;
        conflict     = en0 & en1 & (s_q.waddr1 == s_q.waddr2);
        reg_write_en = {en1, en0 & ~conflict};
    end

    assign reg_write_addr1 = s_q.valid[0] ? s_q.waddr1 : '0;
    assign reg_write_addr2 = s_q.valid[1] ? s_q.waddr2 : '0;
    assign reg_write_data1 = s_q.valid[0] ? s_q.wdata1 : '0;
    assign reg_write_data2 = s_q.valid[1] ? s_q.wdata2 : '0;

    assign fwd_valid = reg_write_en;
    assign fwd_addr1 = reg_write_addr1;
    assign fwd_addr2 = reg_write_addr2;
    assign fwd_data1 = reg_write_data1;
    assign fwd_data2 = reg_write_data2;

`ifdef WB_COMMIT_TRACE_EN
    assign debug_wb_pc1       = s_q.valid[0] ? s_q.pc1 : '0;
    assign debug_wb_pc2       = s_q.valid[1] ? s_q.pc2 : '0;
    assign debug_wb_rf_we     = reg_write_en;
    assign debug_wb_rf_wnum1  = reg_write_addr1;
    assign debug_wb_rf_wnum2  = reg_write_addr2;
    assign debug_wb_rf_wdata1 = reg_write_data1;
    assign debug_wb_rf_wdata2 = reg_write_data2;

    // Count retired instructions (not pairs); wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_cnt <= '0;
        end else if (retire) begin
            commit_cnt <= commit_cnt + {31'b0, s_q.valid[0]} + {31'b0, s_q.valid[1]};
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// tb/tb_wb_commit_stage.sv - randomized self-checking bench for wb_commit_stage against a queue model
module tb_wb_commit_stage;

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] pc1;
        logic [31:0] pc2;
        logic [1:0]  we;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] d1;
        logic [31:0] d2;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        commit_stall;
    logic [1:0]  mem_valid;
    logic        wb_ready;
    logic [31:0] mem_pc1, mem_pc2;
    logic [1:0]  mem_reg_we;
    logic [4:0]  mem_reg_waddr1, mem_reg_waddr2;
    logic [31:0] mem_reg_wdata1, mem_reg_wdata2;
    logic [1:0]  reg_write_en;
    logic [4:0]  reg_write_addr1, reg_write_addr2;
    logic [31:0] reg_write_data1, reg_write_data2;
    logic [1:0]  fwd_valid;
    logic [4:0]  fwd_addr1, fwd_addr2;
    logic [31:0] fwd_data1, fwd_data2;
`ifdef WB_COMMIT_TRACE_EN
    logic [31:0] debug_wb_pc1, debug_wb_pc2;
    logic [1:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum1, debug_wb_rf_wnum2;
    logic [31:0] debug_wb_rf_wdata1, debug_wb_rf_wdata2;
    logic [31:0] commit_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pair_t       q[$];
    logic [31:0] m_cnt = 0;

    always #5 clk = ~clk;

    wb_commit_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .commit_stall    (commit_stall),
        .mem_valid       (mem_valid),
        .wb_ready        (wb_ready),
        .mem_pc1         (mem_pc1),
        .mem_pc2         (mem_pc2),
        .mem_reg_we      (mem_reg_we),
        .mem_reg_waddr1  (mem_reg_waddr1),
        .mem_reg_waddr2  (mem_reg_waddr2),
        .mem_reg_wdata1  (mem_reg_wdata1),
        .mem_reg_wdata2  (mem_reg_wdata2),
        .reg_write_en    (reg_write_en),
        .reg_write_addr1 (reg_write_addr1),
        .reg_write_addr2 (reg_write_addr2),
        .reg_write_data1 (reg_write_data1),
        .reg_write_data2 (reg_write_data2),
        .fwd_valid       (fwd_valid),
        .fwd_addr1       (fwd_addr1),
        .fwd_addr2       (fwd_addr2),
        .fwd_data1       (fwd_data1),
        .fwd_data2       (fwd_data2)
`ifdef WB_COMMIT_TRACE_EN
        ,
        .debug_wb_pc1       (debug_wb_pc1),
        .debug_wb_pc2       (debug_wb_pc2),
        .debug_wb_rf_we     (debug_wb_rf_we),
        .debug_wb_rf_wnum1  (debug_wb_rf_wnum1),
        .debug_wb_rf_wnum2  (debug_wb_rf_wnum2),
        .debug_wb_rf_wdata1 (debug_wb_rf_wdata1),
        .debug_wb_rf_wdata2 (debug_wb_rf_wdata2),
        .commit_cnt         (commit_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    endtask

    function automatic pair_t mk(input logic [1:0] v, input logic [1:0] we,
                                 input logic [4:0] a1, input logic [31:0] d1,
                                 input logic [4:0] a2, input logic [31:0] d2);
        pair_t p;
        p.v = v; p.we = we; p.a1 = a1; p.a2 = a2; p.d1 = d1; p.d2 = d2;
        p.pc1 = 32'h1000 + {d1[11:0], 2'b00};
        p.pc2 = p.pc1 + 32'd4;
        return p;
    endfunction

    function automatic pair_t rnd_pair();
        return mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom);
    endfunction

    // One clock: drive inputs, check outputs against the oldest held pair, advance the model.
    task automatic cycle(input logic st, input logic fl, input pair_t p, output logic gone);
        pair_t h;
        logic  e0, e1, acc, ret;
        @(posedge clk);
        #1;
        commit_stall   = st;
        flush          = fl;
        mem_valid      = p.v;
        mem_pc1        = p.pc1;
        mem_pc2        = p.pc2;
        mem_reg_we     = p.we;
        mem_reg_waddr1 = p.a1;
        mem_reg_waddr2 = p.a2;
        mem_reg_wdata1 = p.d1;
        mem_reg_wdata2 = p.d2;
        @(negedge clk);
        h  = (q.size() > 0) ? q[0] : '0;
        e0 = h.v[0] && h.we[0] && (h.a1 != '0) && !st && !fl;
        e1 = h.v[1] && h.we[1] && (h.a2 != '0) && !st && !fl;
        if (e0 && e1 && (h.a1 == h.a2)) e0 = 1'b0;
        chk("wb_ready", 32'(wb_ready), 32'(q.size() < 2));
        chk("reg_write_en", 32'(reg_write_en), 32'({e1, e0}));
        chk("reg_write_addr1", 32'(reg_write_addr1), h.v[0] ? 32'(h.a1) : 32'd0);
        chk("reg_write_addr2", 32'(reg_write_addr2), h.v[1] ? 32'(h.a2) : 32'd0);
        chk("reg_write_data1", reg_write_data1, h.v[0] ? h.d1 : 32'd0);
        chk("reg_write_data2", reg_write_data2, h.v[1] ? h.d2 : 32'd0);
        chk("fwd_valid", 32'(fwd_valid), 32'({e1, e0}));
        chk("fwd_addr2", 32'(fwd_addr2), h.v[1] ? 32'(h.a2) : 32'd0);
        chk("fwd_data1", fwd_data1, h.v[0] ? h.d1 : 32'd0);
`ifdef WB_COMMIT_TRACE_EN
        chk("debug_wb_rf_we", 32'(debug_wb_rf_we), 32'({e1, e0}));
        chk("debug_wb_pc1", debug_wb_pc1, h.v[0] ? h.pc1 : 32'd0);
        chk("debug_wb_pc2", debug_wb_pc2, h.v[1] ? h.pc2 : 32'd0);
        chk("commit_cnt", commit_cnt, m_cnt);
`endif
        acc = (p.v != 2'b00) && (q.size() < 2) && !fl;
        ret = (q.size() > 0) && !st && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (ret) begin
                m_cnt = m_cnt + 32'(q[0].v[0]) + 32'(q[0].v[1]);
                void'(q.pop_front());
            end
            if (acc) q.push_back(p);
        end
        gone = acc || fl || (p.v == 2'b00);
    endtask

    initial begin
        pair_t cur, idle, p1, p2, p3;
        logic  gone;
        idle = '0;
        rst_n = 1'b0; flush = 1'b0; commit_stall = 1'b0; mem_valid = 2'b00;
        mem_pc1 = '0; mem_pc2 = '0; mem_reg_we = '0;
        mem_reg_waddr1 = '0; mem_reg_waddr2 = '0; mem_reg_wdata1 = '0; mem_reg_wdata2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_wb_ready", 32'(wb_ready), 32'd1);
        chk("reset_en", 32'(reg_write_en), 32'd0);
        chk("reset_data2", reg_write_data2, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Five pairs, one slot0-only, back to back; first is {r3<=0x11, r4<=0x22}.
        cycle(1'b0, 1'b0, mk(2'b11, 2'b11, 5'd3, 32'h11, 5'd4, 32'h22), gone);
        cycle(1'b0, 1'b0, mk(2'b11, 2'b11, 5'd6, 32'h33, 5'd7, 32'h44), gone);
        chk("pair_en", 32'(reg_write_en), 32'h3);
        chk("pair_addr1", 32'(reg_write_addr1), 32'd3);
        chk("pair_data2", reg_write_data2, 32'h22);
        cycle(1'b0, 1'b0, mk(2'b01, 2'b01, 5'd8, 32'h55, 5'd9, 32'h66), gone);
        cycle(1'b0, 1'b0, mk(2'b11, 2'b10, 5'd1, 32'h77, 5'd2, 32'h88), gone);
        cycle(1'b0, 1'b0, mk(2'b11, 2'b11, 5'd10, 32'h99, 5'd11, 32'haa), gone);
        cycle(1'b0, 1'b0, idle, gone);
        cycle(1'b0, 1'b0, idle, gone);
`ifdef WB_COMMIT_TRACE_EN
        chk("commit_cnt_9", commit_cnt, 32'd9);
`endif

        // Same destination: younger wins; r0 write suppressed.
        cycle(1'b0, 1'b0, mk(2'b11, 2'b11, 5'd5, 32'ha, 5'd5, 32'hb), gone);
        cycle(1'b0, 1'b0, mk(2'b11, 2'b11, 5'd0, 32'hc, 5'd12, 32'hd), gone);
        chk("conflict_en", 32'(reg_write_en), 32'h2);
        chk("conflict_data2", reg_write_data2, 32'hb);
        cycle(1'b0, 1'b0, idle, gone);
        chk("r0_en", 32'(reg_write_en), 32'h2);

        // Stall with three pairs offered, then release.
        p1 = mk(2'b11, 2'b11, 5'd13, 32'h101, 5'd14, 32'h102);
        p2 = mk(2'b10, 2'b11, 5'd15, 32'h201, 5'd16, 32'h202);
        p3 = mk(2'b11, 2'b11, 5'd17, 32'h301, 5'd18, 32'h302);
        cycle(1'b1, 1'b0, p1, gone);
        cycle(1'b1, 1'b0, p2, gone);
        cycle(1'b1, 1'b0, p3, gone);
        chk("stall_p3_held", 32'(gone), 32'd0);
        chk("stall_ready", 32'(wb_ready), 32'd0);
        cycle(1'b0, 1'b0, p3, gone);
        chk("rel_p1_data1", reg_write_data1, 32'h101);
        cycle(1'b0, 1'b0, p3, gone);
        chk("rel_p2_en", 32'(reg_write_en), 32'h2);
        cycle(1'b0, 1'b0, idle, gone);
        chk("rel_p3_data2", reg_write_data2, 32'h302);

        // Flush with both registers full under stall.
        cycle(1'b1, 1'b0, p1, gone);
        cycle(1'b1, 1'b0, p2, gone);
        cycle(1'b1, 1'b1, p3, gone);
        chk("flush_en", 32'(reg_write_en), 32'd0);
        cycle(1'b0, 1'b0, idle, gone);
        chk("flush_ready", 32'(wb_ready), 32'd1);

        // Asynchronous reset in the middle of a cycle with a pair held.
        cycle(1'b0, 1'b0, mk(2'b11, 2'b11, 5'd20, 32'h401, 5'd21, 32'h402), gone);
        @(posedge clk);
        #1 mem_valid = 2'b00; commit_stall = 1'b0; flush = 1'b0;
        #1 chk("pre_reset_en", 32'(reg_write_en), 32'h3);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_en", 32'(reg_write_en), 32'd0);
        chk("async_reset_ready", 32'(wb_ready), 32'd1);
        @(negedge clk);
        chk("reset_hold_en", 32'(reg_write_en), 32'd0);
        q.delete();
        m_cnt = 0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Random traffic; MEM holds an unaccepted pair unchanged.
        cur = rnd_pair();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), cur, gone);
            if (gone) cur = rnd_pair();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
